// File: rtl/sumador_multiciclo_ctrl_if.sv
// Handshake and data bundle between the ALU issue logic (master) and the
// multi-cycle add/subtract sequencer (slave).
// Optional macro: SUMADOR_OVERFLOW_EN adds the Overflow signal to the bundle.
interface sumador_multiciclo_ctrl_if #(
  parameter int WIDTH = 32
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] Operando1;
  logic [WIDTH-1:0] Operando2;
  logic             CarryIn;
  logic             Resta;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Resultado;
  logic             CarryOut;
`ifdef SUMADOR_OVERFLOW_EN
  logic             Overflow;

  modport master (
    output in_valid, Operando1, Operando2, CarryIn, Resta, out_ready,
    input  in_ready, out_valid, Resultado, CarryOut, Overflow
  );
  modport slave (
    input  in_valid, Operando1, Operando2, CarryIn, Resta, out_ready,
    output in_ready, out_valid, Resultado, CarryOut, Overflow
  );
`else
  modport master (
    output in_valid, Operando1, Operando2, CarryIn, Resta, out_ready,
    input  in_ready, out_valid, Resultado, CarryOut
  );
  modport slave (
    input  in_valid, Operando1, Operando2, CarryIn, Resta, out_ready,
    output in_ready, out_valid, Resultado, CarryOut
  );
`endif
endinterface

// File: rtl/sumador_multiciclo_ctrl.sv
// Multi-cycle WIDTH-bit add/subtract sequencer. One SLICE-bit carry
// lookahead adder is reused over NS = WIDTH/SLICE cycles, least significant
// slice first, with the inter-slice carry held in a register.
// Optional macro: SUMADOR_OVERFLOW_EN enables the signed Overflow output.

// SLICE-bit carry lookahead adder: every carry is a flat sum of products of
// generate/propagate terms, so no carry ripples through earlier bits.
module CarryLookAheadSumador #(
  parameter int N = 8
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         c_i,
  output logic [N-1:0] s_o,
  output logic         c_o
);
  logic [N-1:0] gen;
  logic [N-1:0] prop;
  logic [N:0]   carry;

  assign gen  = a_i & b_i;
  assign prop = a_i ^ b_i;

  // Carry into bit k: cin propagated through bits 0..k-1, OR any bit j<k
  // that generates and is propagated through bits j+1..k-1.
  function automatic logic carry_into(input logic [N-1:0] gv,
                                      input logic [N-1:0] pv,
                                      input logic         cin,
                                      input int           k);
    logic acc;
    logic run;
    run = cin;
    for (int m = 0; m < k; m++) run = run & pv[m];
    acc = run;
    for (int j = 0; j < k; j++) begin
      run = gv[j];
      for (int m = j + 1; m < k; m++) run = run & pv[m];
      acc = acc | run;
    end
    return acc;
  endfunction

  for (genvar gi = 0; gi <= N; gi++) begin : g_carry
    assign carry[gi] = carry_into(gen, prop, c_i, gi);
  end

  assign s_o = prop ^ carry[N-1:0];
  assign c_o = carry[N];
endmodule

module sumador_multiciclo_ctrl #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input logic                      clk,
  input logic                      rst_n,
  sumador_multiciclo_ctrl_if.slave bus
);
  localparam int NS   = (SLICE >= 1) ? (WIDTH / SLICE) : 1;
  localparam int IDXW = (NS > 1) ? $clog2(NS) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NS - 1);

  if ((SLICE < 1) || ((WIDTH % ((SLICE < 1) ? 1 : SLICE)) != 0)) begin : g_bad_cfg
    $error("sumador_multiciclo_ctrl: WIDTH must be a positive multiple of SLICE");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } state_t;

  state_t           state_q;
  logic [IDXW-1:0]  idx_q;
  logic [IDXW-1:0]  idx_d;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry_q;
  logic             carry_d;
  logic [SLICE-1:0] res_slice_q [NS];
  logic             in_ready_q;
  logic             out_valid_q;
`ifdef SUMADOR_OVERFLOW_EN
  logic             ovf_q;
`endif

  // Operands viewed as arrays of slices so the active one is a plain index.
  logic [SLICE-1:0] a_slices [NS];
  logic [SLICE-1:0] b_slices [NS];
  logic [SLICE-1:0] slice_a;
  logic [SLICE-1:0] slice_b;
  logic [SLICE-1:0] slice_sum;

  for (genvar gi = 0; gi < NS; gi++) begin : g_slices
    assign a_slices[gi] = a_q[gi*SLICE +: SLICE];
    assign b_slices[gi] = b_q[gi*SLICE +: SLICE];
    assign bus.Resultado[gi*SLICE +: SLICE] = res_slice_q[gi];
  end

  assign slice_a = a_slices[idx_q];
  assign slice_b = b_slices[idx_q];
  assign idx_d   = idx_q + 1'b1;

  CarryLookAheadSumador #(.N(SLICE)) u_slice_adder (
    .a_i (slice_a),
    .b_i (slice_b),
    .c_i (carry_q),
    .s_o (slice_sum),
    .c_o (carry_d)
  );

  // Control FSM: accept in IDLE, one slice per cycle in BUSY, hold in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      for (int i = 0; i < NS; i++) res_slice_q[i] <= '0;
`ifdef SUMADOR_OVERFLOW_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.in_valid) begin
            // Subtraction is A + ~B + 1; the caller's CarryIn is ignored then.
            a_q        <= bus.Operando1;
            b_q        <= bus.Operando2 ^ {WIDTH{bus.Resta}};
            carry_q    <= bus.Resta ? 1'b1 : bus.CarryIn;
            idx_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          res_slice_q[idx_q] <= slice_sum;
          carry_q            <= carry_d;
          if (idx_q == LAST_IDX) begin
            out_valid_q <= 1'b1;
            state_q     <= ST_DONE;
`ifdef SUMADOR_OVERFLOW_EN
            // The last slice produces the result MSB, so overflow is known now.
            ovf_q <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                     (slice_sum[SLICE-1] != a_q[WIDTH-1]);
`endif
          end else begin
            idx_q <= idx_d;
          end
        end
        ST_DONE: begin
          // No bypass: in_ready only rises the cycle after the output handshake.
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.CarryOut  = carry_q;
`ifdef SUMADOR_OVERFLOW_EN
  assign bus.Overflow  = ovf_q;
`endif
endmodule

// File: tb/tb_sumador_multiciclo_ctrl.sv
// Directed and randomised bench for sumador_multiciclo_ctrl with three
// configurations: W32/S8 (main), W16/S4 and W32/S32.
// Optional macro: SUMADOR_OVERFLOW_EN enables the Overflow checks.
module tb_sumador_multiciclo_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   sel      = 0;

  logic        tb_in_valid;
  logic        tb_cin;
  logic        tb_sub;
  logic        tb_out_ready;
  logic [31:0] tb_a;
  logic [31:0] tb_b;

  sumador_multiciclo_ctrl_if #(.WIDTH(32)) if_a ();
  sumador_multiciclo_ctrl_if #(.WIDTH(16)) if_b ();
  sumador_multiciclo_ctrl_if #(.WIDTH(32)) if_c ();

  assign if_a.in_valid  = tb_in_valid && (sel == 0);
  assign if_a.Operando1 = tb_a;
  assign if_a.Operando2 = tb_b;
  assign if_a.CarryIn   = tb_cin;
  assign if_a.Resta     = tb_sub;
  assign if_a.out_ready = tb_out_ready && (sel == 0);

  assign if_b.in_valid  = tb_in_valid && (sel == 1);
  assign if_b.Operando1 = tb_a[15:0];
  assign if_b.Operando2 = tb_b[15:0];
  assign if_b.CarryIn   = tb_cin;
  assign if_b.Resta     = tb_sub;
  assign if_b.out_ready = tb_out_ready && (sel == 1);

  assign if_c.in_valid  = tb_in_valid && (sel == 2);
  assign if_c.Operando1 = tb_a;
  assign if_c.Operando2 = tb_b;
  assign if_c.CarryIn   = tb_cin;
  assign if_c.Resta     = tb_sub;
  assign if_c.out_ready = tb_out_ready && (sel == 2);

  sumador_multiciclo_ctrl #(.WIDTH(32), .SLICE(8))  dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
  sumador_multiciclo_ctrl #(.WIDTH(16), .SLICE(4))  dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b));
  sumador_multiciclo_ctrl #(.WIDTH(32), .SLICE(32)) dut_c (.clk(clk), .rst_n(rst_n), .bus(if_c));

  // Outputs of the currently selected instance.
  logic        m_valid;
  logic        m_ready;
  logic        m_co;
  logic        m_ovf;
  logic [31:0] m_res;

  always_comb begin
    m_valid = if_a.out_valid;
    m_ready = if_a.in_ready;
    m_res   = if_a.Resultado;
    m_co    = if_a.CarryOut;
    m_ovf   = 1'b0;
`ifdef SUMADOR_OVERFLOW_EN
    m_ovf   = if_a.Overflow;
`endif
    if (sel == 1) begin
      m_valid = if_b.out_valid;
      m_ready = if_b.in_ready;
      m_res   = {16'h0000, if_b.Resultado};
      m_co    = if_b.CarryOut;
`ifdef SUMADOR_OVERFLOW_EN
      m_ovf   = if_b.Overflow;
`endif
    end else if (sel == 2) begin
      m_valid = if_c.out_valid;
      m_ready = if_c.in_ready;
      m_res   = if_c.Resultado;
      m_co    = if_c.CarryOut;
`ifdef SUMADOR_OVERFLOW_EN
      m_ovf   = if_c.Overflow;
`endif
    end
  end

  // One operation on the selected instance: accept, count edges to
  // out_valid, stall the consumer, handshake, then sample in_ready.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic cin, input logic sub, input int stall,
                        output logic [31:0] res, output logic co,
                        output logic ovf, output int lat,
                        output logic ready_after);
    int cnt;
    @(negedge clk);
    tb_a = a; tb_b = b; tb_cin = cin; tb_sub = sub;
    tb_in_valid = 1'b1; tb_out_ready = 1'b0;
    @(negedge clk);
    // Scramble operands after the accepting edge; they must not matter.
    tb_in_valid = 1'b0; tb_a = ~a; tb_b = $urandom; tb_cin = ~cin; tb_sub = ~sub;
    cnt = 0;
    while (!m_valid && cnt < 64) begin
      @(negedge clk);
      cnt++;
    end
    lat = cnt;
    if (cnt >= 64) begin
      n_checks++; n_fail++;
      $display("FAIL timeout sel=%0d: out_valid never rose, required within 64 cycles", sel);
      res = '0; co = 1'b0; ovf = 1'b0; ready_after = 1'b0;
      return;
    end
    repeat (stall) @(negedge clk);
    res = m_res; co = m_co; ovf = m_ovf;
    tb_out_ready = 1'b1;
    @(negedge clk);
    tb_out_ready = 1'b0;
    ready_after = m_ready;
    $display("op sel=%0d a=%h b=%h cin=%0d sub=%0d -> res=%h co=%0d ovf=%0d lat=%0d",
             sel, a, b, cin, sub, res, co, ovf, lat);
  endtask

  task automatic test_reset();
    sel = 0;
    tb_in_valid = 1'b0; tb_out_ready = 1'b0; tb_a = '0; tb_b = '0;
    tb_cin = 1'b0; tb_sub = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (m_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b required 1", m_ready); end
    n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b required 0", m_valid); end
    n_checks++; if (m_res !== 32'h0) begin n_fail++; $display("FAIL reset_resultado: got %h required 00000000", m_res); end
    n_checks++; if (m_co !== 1'b0) begin n_fail++; $display("FAIL reset_carryout: got %b required 0", m_co); end
  endtask

  task automatic test_add();
    logic [31:0] res; logic co, ovf, rdy; int lat;
    sel = 0;
    run_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 0, res, co, ovf, lat, rdy);
    n_checks++; if (res !== 32'h0) begin n_fail++; $display("FAIL add_wrap_res: got %h required 00000000", res); end
    n_checks++; if (co !== 1'b1) begin n_fail++; $display("FAIL add_wrap_co: got %b required 1", co); end
    n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL add_latency: got %0d required 4", lat); end
    n_checks++; if (rdy !== 1'b1) begin n_fail++; $display("FAIL add_ready_after: got %b required 1", rdy); end
    run_op(32'h00000001, 32'h00000002, 1'b1, 1'b0, 2, res, co, ovf, lat, rdy);
    n_checks++; if (res !== 32'h4) begin n_fail++; $display("FAIL add_cin_res: got %h required 00000004", res); end
    n_checks++; if (co !== 1'b0) begin n_fail++; $display("FAIL add_cin_co: got %b required 0", co); end
    run_op(32'h00FF00FF, 32'h00010001, 1'b0, 1'b0, 0, res, co, ovf, lat, rdy);
    n_checks++; if (res !== 32'h01000100) begin n_fail++; $display("FAIL add_slice_carry: got %h required 01000100", res); end
  endtask

  task automatic test_sub();
    logic [31:0] res; logic co, ovf, rdy; int lat;
    sel = 0;
    run_op(32'h00000005, 32'h00000007, 1'b1, 1'b1, 0, res, co, ovf, lat, rdy);
    n_checks++; if (res !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL sub_neg_res: got %h required FFFFFFFE", res); end
    n_checks++; if (co !== 1'b0) begin n_fail++; $display("FAIL sub_neg_co: got %b required 0", co); end
`ifdef SUMADOR_OVERFLOW_EN
    n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL sub_neg_ovf: got %b required 0", ovf); end
`endif
    run_op(32'h00000007, 32'h00000005, 1'b0, 1'b1, 1, res, co, ovf, lat, rdy);
    n_checks++; if (res !== 32'h2) begin n_fail++; $display("FAIL sub_pos_res: got %h required 00000002", res); end
    n_checks++; if (co !== 1'b1) begin n_fail++; $display("FAIL sub_pos_co: got %b required 1", co); end
  endtask

  task automatic test_stall();
    int  cnt;
    logic seen;
    sel = 0;
    @(negedge clk);
    tb_a = 32'h10; tb_b = 32'h20; tb_cin = 1'b0; tb_sub = 1'b0; tb_in_valid = 1'b1;
    @(negedge clk);
    tb_in_valid = 1'b0;
    cnt = 0;
    while (!m_valid && cnt < 64) begin @(negedge clk); cnt++; end
    n_checks++; if (cnt !== 4) begin n_fail++; $display("FAIL stall_latency: got %0d required 4", cnt); end
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (m_res !== 32'h30 || m_valid !== 1'b1 || m_ready !== 1'b0 || m_co !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hold cyc=%0d: got res=%h v=%b rdy=%b co=%b required res=00000030 v=1 rdy=0 co=0",
                 i, m_res, m_valid, m_ready, m_co);
      end
      if (i == 3) begin tb_a = 32'h100; tb_b = 32'h200; tb_in_valid = 1'b1; end
      if (i == 4) tb_in_valid = 1'b0;
      @(negedge clk);
    end
    tb_out_ready = 1'b1;
    @(negedge clk);
    tb_out_ready = 1'b0;
    n_checks++; if (m_ready !== 1'b1) begin n_fail++; $display("FAIL stall_idle_next: in_ready got %b required 1", m_ready); end
    n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL stall_valid_drop: out_valid got %b required 0", m_valid); end
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin @(negedge clk); if (m_valid) seen = 1'b1; end
    n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL stall_pulse_queued: out_valid seen %b required 0", seen); end
    $display("op stall sel=0 a=00000010 b=00000020 held 10 cycles");
  endtask

  task automatic test_reset_busy();
    logic [31:0] res; logic co, ovf, rdy; int lat;
    sel = 0;
    @(negedge clk);
    tb_a = 32'hFFFF0000; tb_b = 32'h0000FFFF; tb_cin = 1'b0; tb_sub = 1'b0; tb_in_valid = 1'b1;
    @(negedge clk);
    tb_in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++; if (m_res !== 32'h0) begin n_fail++; $display("FAIL rst_busy_res: got %h required 00000000", m_res); end
    n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL rst_busy_valid: got %b required 0", m_valid); end
    n_checks++; if (m_co !== 1'b0) begin n_fail++; $display("FAIL rst_busy_co: got %b required 0", m_co); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (m_ready !== 1'b1) begin n_fail++; $display("FAIL rst_busy_ready: got %b required 1", m_ready); end
    run_op(32'h12345678, 32'h11111111, 1'b0, 1'b0, 0, res, co, ovf, lat, rdy);
    n_checks++; if (res !== 32'h23456789) begin n_fail++; $display("FAIL rst_after_res: got %h required 23456789", res); end
    n_checks++; if (co !== 1'b0) begin n_fail++; $display("FAIL rst_after_co: got %b required 0", co); end
  endtask

`ifdef SUMADOR_OVERFLOW_EN
  task automatic test_overflow();
    logic [31:0] res; logic co, ovf, rdy; int lat;
    sel = 0;
    run_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 0, res, co, ovf, lat, rdy);
    n_checks++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_add: got %b required 1", ovf); end
    n_checks++; if (res !== 32'h80000000) begin n_fail++; $display("FAIL ovf_add_res: got %h required 80000000", res); end
    run_op(32'h80000000, 32'h00000001, 1'b0, 1'b1, 0, res, co, ovf, lat, rdy);
    n_checks++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_sub: got %b required 1", ovf); end
    n_checks++; if (res !== 32'h7FFFFFFF) begin n_fail++; $display("FAIL ovf_sub_res: got %h required 7FFFFFFF", res); end
    run_op(32'h00000001, 32'h00000001, 1'b0, 1'b0, 0, res, co, ovf, lat, rdy);
    n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_none: got %b required 0", ovf); end
  endtask
`endif

  task automatic test_random();
    logic [31:0] a, b, bp, mask, exp_res, res;
    logic [32:0] s;
    logic cin, sub, co, ovf, rdy, exp_co, exp_ovf;
    int lat, w, exp_lat;
    for (int cfg = 0; cfg < 3; cfg++) begin
      sel     = cfg;
      w       = (cfg == 1) ? 16 : 32;
      mask    = (cfg == 1) ? 32'h0000FFFF : 32'hFFFFFFFF;
      exp_lat = (cfg == 2) ? 1 : 4;
      for (int n = 0; n < 334; n++) begin
        a   = $urandom & mask;
        b   = $urandom & mask;
        cin = 1'($urandom_range(0, 1));
        sub = 1'($urandom_range(0, 1));
        bp  = (sub ? ~b : b) & mask;
        s   = {1'b0, a} + {1'b0, bp} + {32'h0, (sub ? 1'b1 : cin)};
        exp_res = s[31:0] & mask;
        exp_co  = (w == 16) ? s[16] : s[32];
        exp_ovf = (a[w-1] == bp[w-1]) && (exp_res[w-1] != a[w-1]);
        run_op(a, b, cin, sub, $urandom_range(0, 3), res, co, ovf, lat, rdy);
        n_checks++;
        if (res !== exp_res || co !== exp_co) begin
          n_fail++;
          $display("FAIL rand_result sel=%0d a=%h b=%h sub=%0d: got %h/%b required %h/%b",
                   sel, a, b, sub, res, co, exp_res, exp_co);
        end
        n_checks++;
        if (lat !== exp_lat || rdy !== 1'b1) begin
          n_fail++;
          $display("FAIL rand_timing sel=%0d: got lat=%0d rdy=%b required lat=%0d rdy=1",
                   sel, lat, rdy, exp_lat);
        end
`ifdef SUMADOR_OVERFLOW_EN
        n_checks++;
        if (ovf !== exp_ovf) begin
          n_fail++;
          $display("FAIL rand_ovf sel=%0d a=%h b=%h sub=%0d: got %b required %b",
                   sel, a, b, sub, ovf, exp_ovf);
        end
`else
        if (exp_ovf && ovf) $display("note: overflow model unused without overflow build");
`endif
      end
    end
    sel = 0;
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_stall();
    test_reset_busy();
`ifdef SUMADOR_OVERFLOW_EN
    test_overflow();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #900us;
    $display("FAIL watchdog: simulation exceeded time limit, required completion before 900us");
    $fatal(1, "watchdog expired");
  end
endmodule
